// File: rtl/apb4_mem_slave.sv
// APB4 scratch/config RAM slave: byte strobes, fixed wait states, a write-protected
// low region and PSLVERR for out-of-range, unaligned and protected accesses.
module apb4_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1,
  parameter int RO_WORDS    = 0
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDR_WIDTH-1:0]     paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pready,
  output logic                      pslverr
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] RO_LIM    = (ADDR_WIDTH + 1)'(RO_WORDS);
  localparam logic [3:0]          WS        = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [IW-1:0]           idx_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [BYTES-1:0]        strb_q;
  logic                    err_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   index;
  logic [ADDR_WIDTH:0]     index_x;
  logic [IW-1:0]           rd_idx;
  logic                    unaligned;
  logic                    ro_hit;
  logic                    err;
  logic                    commit;

  assign index   = paddr >> LSB;
  assign index_x = {1'b0, index};
  assign rd_idx  = index[IW-1:0];

  generate
    if (LSB > 0) begin : g_align
      assign unaligned = (paddr[LSB-1:0] != '0);
    end else begin : g_no_align
      assign unaligned = 1'b0;
    end
    if (RO_WORDS > 0) begin : g_ro
      assign ro_hit = pwrite && (index_x < RO_LIM);
    end else begin : g_no_ro
      assign ro_hit = 1'b0;
    end
  endgenerate

  assign err = (index_x >= DEPTH_LIM) || unaligned || ro_hit;

  // Outputs depend on registered state only, so there is no input-to-output path.
  assign pready  = (state == ACCESS) && (cnt == 4'd0);
  assign pslverr = pready && err_q;

  // Writes commit at the completion edge; a dropped psel (abort) suppresses them.
  assign commit = (state == ACCESS) && psel && (cnt == 4'd0) && write_q && !err_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      prdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state   <= ACCESS;
            idx_q   <= rd_idx;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
            err_q   <= err;
            cnt     <= WS;
            if (!pwrite) prdata <= err ? '0 : mem[rd_idx];
          end
        end
        ACCESS: begin
          if (!psel) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            if (penable) cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (strb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: three instances (wait states 1/0/3, one with a protected
// low region) driven by directed and random transfers against a byte-level memory model.
module tb_apb4_mem_slave;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 256;

  logic           pclk = 1'b0;
  logic           presetn;
  logic           penable;
  logic           pwrite;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  pwdata;
  logic [NB-1:0]  pstrb;
  logic           psel_v    [3];
  logic [DW-1:0]  prdata_v  [3];
  logic           pready_v  [3];
  logic           pslverr_v [3];

  always #5 pclk = ~pclk;

  apb4_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(1), .RO_WORDS(4)) dut_a (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0]));

  apb4_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(0), .RO_WORDS(0)) dut_b (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1]));

  apb4_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(3), .RO_WORDS(0)) dut_c (
    .pclk(pclk), .presetn(presetn), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2]));

  // Reference model: per-instance word store plus a mask of bytes known to be written.
  int            ws_of [3] = '{1, 0, 3};
  int            ro_of [3] = '{4, 0, 0};
  logic [31:0]   mdl   [3][DEPTH];
  logic [3:0]    known [3][DEPTH];
  logic [31:0]   last_exp [3];
  logic [31:0]   last_msk [3];

  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic [31:0] byte_mask(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < 3; i++) psel_v[i] = 1'b0;
    penable = 1'b0;
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completion edge.
  task automatic xfer(input int d, input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er, output int cyc);
    for (int i = 0; i < 3; i++) psel_v[i] = (i == d);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    pstrb   = st;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    cyc = 1;
    @(negedge pclk);
    while (!pready_v[d] && cyc < 40) begin
      @(posedge pclk);
      #1;
      cyc++;
      @(negedge pclk);
    end
    rd = prdata_v[d];
    er = pslverr_v[d];
    @(posedge pclk);
    #1;
  endtask

  task automatic run(input int d, input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input string tag, output logic [31:0] rd, output logic er);
    int          idx;
    int          cyc;
    bit          e_err;
    logic [31:0] e_rd;
    logic [31:0] m;
    idx   = int'(a) / 4;
    e_err = (idx >= DEPTH) || (int'(a) % 4 != 0) || (wr && idx < ro_of[d]);
    e_rd  = '0;
    m     = '1;
    if (!wr && !e_err) begin
      e_rd = mdl[d][idx];
      m    = byte_mask(known[d][idx]);
    end
    xfer(d, wr, a, wd, st, rd, er, cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'(ws_of[d] + 1));
    chk({tag, "_err"}, {31'd0, er}, {31'd0, e_err});
    if (!wr) begin
      chk({tag, "_rdata"}, rd & m, e_rd & m);
      last_exp[d] = e_rd;
      last_msk[d] = m;
    end else begin
      chk({tag, "_hold"}, rd & last_msk[d], last_exp[d] & last_msk[d]);
      if (!e_err) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) begin
            mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
            known[d][idx][b]      = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5)      return AW'($urandom_range(0, DEPTH - 1) * 4);
    else if (r == 6) return AW'($urandom_range(0, 7) * 4);
    else if (r == 7) return AW'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
    else if (r == 8) return AW'($urandom_range(DEPTH, 1023) * 4);
    else             return AW'($urandom_range(0, 5) * 4);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] wd;

    presetn = 1'b0;
    idle(0);
    pwrite = 1'b0;
    paddr  = '0;
    pwdata = '0;
    pstrb  = '0;
    for (int d = 0; d < 3; d++) begin
      last_exp[d] = '0;
      last_msk[d] = '1;
      for (int i = 0; i < DEPTH; i++) begin
        mdl[d][i]   = '0;
        known[d][i] = '0;
      end
    end
    repeat (3) @(posedge pclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_pready", {31'd0, pready_v[d]}, 32'd0);
      chk("rst_pslverr", {31'd0, pslverr_v[d]}, 32'd0);
      chk("rst_prdata", prdata_v[d], 32'd0);
    end
    presetn = 1'b1;
    idle(2);

    // Basic write/read with one wait state
    run(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, "t1_wr", rd, er);
    run(0, 1'b0, 12'h010, 32'h0, 4'hF, "t1_rd", rd, er);
    chk("t1_val", rd, 32'hDEADBEEF);
    idle(1);

    // Byte strobes
    run(0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'hF, "t2_wr_all", rd, er);
    run(0, 1'b1, 12'h020, 32'h12345678, 4'b0101, "t2_wr_strb", rd, er);
    run(0, 1'b0, 12'h020, 32'h0, 4'h0, "t2_rd", rd, er);
    chk("t2_val", rd, 32'hFF34FF78);

    // Error responses
    run(0, 1'b0, 12'h400, 32'h0, 4'hF, "t3_oor", rd, er);
    chk("t3_oor_data", rd, 32'h0);
    chk("t3_oor_err", {31'd0, er}, 32'd1);
    run(0, 1'b1, 12'h011, 32'h0BADF00D, 4'hF, "t3_unal", rd, er);
    chk("t3_unal_err", {31'd0, er}, 32'd1);
    run(0, 1'b0, 12'h010, 32'h0, 4'hF, "t3_rb", rd, er);
    chk("t3_rb_val", rd, 32'hDEADBEEF);

    // Protected low region
    run(0, 1'b1, 12'h00C, 32'hA5A5A5A5, 4'hF, "t4_ro_wr", rd, er);
    chk("t4_ro_err", {31'd0, er}, 32'd1);
    run(0, 1'b0, 12'h00C, 32'h0, 4'hF, "t4_ro_rd", rd, er);
    chk("t4_ro_kept", {31'd0, rd == 32'hA5A5A5A5}, 32'd0);
    run(0, 1'b1, 12'h010, 32'h5AC3_3C5A, 4'hF, "t4_rw_wr", rd, er);
    chk("t4_rw_err", {31'd0, er}, 32'd0);
    run(0, 1'b0, 12'h010, 32'h0, 4'hF, "t4_rw_rd", rd, er);
    chk("t4_rw_val", rd, 32'h5AC3_3C5A);

    // Empty-strobe write leaves memory alone
    run(0, 1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, "t_strb0_wr", rd, er);
    run(0, 1'b0, 12'h010, 32'h0, 4'hF, "t_strb0_rd", rd, er);
    chk("t_strb0_val", rd, 32'h5AC3_3C5A);

    // penable without a setup phase must not start a transfer
    psel_v[0] = 1'b1;
    penable   = 1'b1;
    pwrite    = 1'b1;
    paddr     = 12'h010;
    repeat (3) begin
      @(negedge pclk);
      chk("t_pen_idle", {31'd0, pready_v[0]}, 32'd0);
    end
    @(posedge pclk);
    #1;
    idle(1);
    run(0, 1'b0, 12'h010, 32'h0, 4'hF, "t_pen_rd", rd, er);

    // Zero wait states, back-to-back alternating write/read
    idle(1);
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      run(1, 1'b1, AW'(i * 4), wd, 4'hF, "t5_wr", rd, er);
      run(1, 1'b0, AW'(i * 4), 32'h0, 4'hF, "t5_rd", rd, er);
      chk("t5_raw", rd, wd);
    end
    idle(1);

    // Reset in the middle of a three-wait-state write
    run(2, 1'b1, 12'h040, 32'h5A5A5A5A, 4'hF, "t6_pre_wr", rd, er);
    run(2, 1'b1, 12'h080, 32'hCAFEF00D, 4'hF, "t6_pre_wr2", rd, er);
    run(2, 1'b0, 12'h080, 32'h0, 4'hF, "t6_pre_rd", rd, er);
    for (int i = 0; i < 3; i++) psel_v[i] = (i == 2);
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 12'h040;
    pwdata  = 32'hBAD0BAD0;
    pstrb   = 4'hF;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    @(posedge pclk);
    #1;
    presetn = 1'b0;
    #1;
    chk("t6_rst_pready", {31'd0, pready_v[2]}, 32'd0);
    chk("t6_rst_pslverr", {31'd0, pslverr_v[2]}, 32'd0);
    chk("t6_rst_prdata", prdata_v[2], 32'd0);
    @(posedge pclk);
    #1;
    idle(1);
    chk("t6_rst_hold", {31'd0, pready_v[2]}, 32'd0);
    presetn = 1'b1;
    for (int d = 0; d < 3; d++) begin
      last_exp[d] = '0;
      last_msk[d] = '1;
    end
    idle(1);
    run(2, 1'b0, 12'h040, 32'h0, 4'hF, "t6_dropped", rd, er);
    chk("t6_dropped_val", rd, 32'h5A5A5A5A);
    run(2, 1'b1, 12'h040, 32'h11111111, 4'hF, "t6_wr", rd, er);
    run(2, 1'b0, 12'h040, 32'h0, 4'hF, "t6_rd", rd, er);
    chk("t6_val", rd, 32'h11111111);
    idle(1);

    // Randomized traffic on every instance
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 120; n++) begin
        run(d, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)),
            "rnd", rd, er);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/apb4_mem_slave.md
Name: apb4_mem_slave

Overview:
- Parametrised APB4 memory-mapped slave. It is the successor to the team's fixed 32-bit / 256-word APB slave.
- Adds the following, which the previous block lacks:
  - configurable data width and depth
  - byte strobes (PSTRB)
  - a configurable fixed wait-state count
  - a write-protected low region
  - real PSLVERR generation for out-of-range, unaligned and protected accesses
- Sits behind the APB bridge as a scratch/config RAM and is the target of the UVM APB agent.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 12, PADDR width in bits; PADDR is a byte address.
- DEPTH, 256, number of DATA_WIDTH-bit words; 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- WAIT_STATES, 1, number of ACCESS cycles with PREADY low before completion; 0..15.
- RO_WORDS, 0, words 0..RO_WORDS-1 are read-only; a write there gives PSLVERR.

Ports:
- pclk, input, 1, APB clock.
- presetn, input, 1, reset.
- psel, input, 1, slave select.
- penable, input, 1, access phase.
- pwrite, input, 1, 1 = write, 0 = read.
- paddr, input, ADDR_WIDTH, byte address.
- pwdata, input, DATA_WIDTH, write data.
- pstrb, input, DATA_WIDTH/8, byte write enables.
- prdata, output, DATA_WIDTH, read data; valid when pready is high.
- pready, output, 1, transfer completion.
- pslverr, output, 1, error response; valid only when pready is high.

Behaviour:
- Reset presetn is asynchronous, active-low; clock is pclk.
- Values on reset:
  - state = IDLE, wait counter = 0, latched address/control = 0.
  - prdata = 0, pready = 0, pslverr = 0.
  - Memory array is not reset; its contents are undefined until written.
- Word index = paddr >> log2(DATA_WIDTH/8). A transfer is aligned when the low log2(DATA_WIDTH/8) paddr bits are 0.
- Error condition `err`, evaluated in the SETUP cycle and latched:
  - index >= DEPTH, or
  - unaligned address, or
  - write with index < RO_WORDS.
- FSM states are IDLE and ACCESS.
  - IDLE -> ACCESS on the clock edge where psel=1 and penable=0 (the SETUP phase).
    - At that edge: latch paddr, pwrite, pwdata, pstrb and err.
    - Load the counter with WAIT_STATES.
    - For a read with err=0, load the prdata register with mem[index]. For a read with err=1, load 0.
  - ACCESS, psel=1, penable=1, counter > 0: decrement the counter; pready=0.
  - ACCESS, counter == 0: pready=1, pslverr=err_latched.
    - For a write with err=0, update each byte b where pstrb[b]=1 at this edge. Bytes with pstrb[b]=0 keep their old value.
    - Next state is IDLE.
  - ACCESS with psel=0 (master abort): return to IDLE, no memory update, pready stays 0.
- pready and pslverr are combinational from registered state only, with no input-to-output path. Both are 0 outside ACCESS.
- Latency: a transfer completes exactly WAIT_STATES+1 cycles after the SETUP edge. WAIT_STATES=0 gives zero-wait APB (2-cycle transfer).
- A read with all pstrb=0 is legal; pstrb is ignored on reads.
- A write with pstrb=0 completes with no memory change and pslverr=0.
- An errored write never modifies memory. An errored read returns prdata=0.
- prdata holds its last value until the next read SETUP edge; writes do not change prdata.
- Back-to-back transfers: a SETUP in the cycle after completion is accepted with no idle cycle.
- Read-after-write to the same word in back-to-back transfers returns the newly written data, because the write commits at the completion edge, before the next SETUP edge.
- Reset asserted mid-transfer:
  - Immediately drive pready=0, pslverr=0, prdata=0 and state=IDLE.
  - An in-flight write is dropped if reset precedes its completion edge.
- penable=1 while in IDLE (protocol violation) is ignored; the FSM stays in IDLE.

Test Plan:
1. Config DATA_WIDTH=32, WAIT_STATES=1. Write 0xDEADBEEF to 0x010 with pstrb=4'hF, then read 0x010. Expected: each transfer has pready low for 1 ACCESS cycle then high; read returns 0xDEADBEEF; pslverr=0.
2. Byte strobes. Write 0xFFFFFFFF to 0x020, then write 0x12345678 with pstrb=4'b0101, then read 0x020. Expected: prdata=0xFF34FF78.
3. Error cases, DEPTH=256:
   - Read 0x400 (index 256): pslverr=1 with pready, prdata=0.
   - Write 0x011 (unaligned): pslverr=1; a readback of 0x010 is unchanged.
4. RO_WORDS=4. Write 0xA5A5A5A5 to 0x00C. Expected: pslverr=1 and mem[3] unchanged. Write to 0x010. Expected: pslverr=0 and data stored.
5. WAIT_STATES=0, 8 back-to-back alternating writes/reads to 0x000..0x01C. Expected: every transfer completes in 2 cycles with no idle gaps; each read returns the word written immediately before it.
6. Start a write to 0x040 in WAIT_STATES=3 mode and assert presetn low in the 2nd ACCESS cycle. Expected: pready/pslverr/prdata go 0 asynchronously and state returns to IDLE. After release, write 0x11111111 to 0x040 and read it back: returns 0x11111111.
